// File: rtl/wb_arbiter_rr_pkg.sv
// Shared types and Wishbone bus widths for the two-master round-robin arbiter.
package wb_arb_pkg;

  localparam int ADR_W = 30;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Index of a master; 0 = sentinel core, 1 = DMA/debug.
  typedef logic idx_t;

  // Round-robin pick among current requesters; on a tie the master that
  // was not granted last wins.
  function automatic arb_state_t arb_pick(input logic req0, input logic req1,
                                          input idx_t last);
    if (req0 && req1) return (last == 1'b1) ? GNT0 : GNT1;
    if (req0)         return GNT0;
    if (req1)         return GNT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Wishbone classic bus bundle. "master" is the side that issues cycles,
// "slave" is the side that answers them.
interface wb_arbiter_rr_if;
  import wb_arb_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic             ack;
  logic             err;

  modport master (output cyc, stb, we, adr, sel, dat_w,
                  input  dat_r, ack);
  modport slave  (input  cyc, stb, we, adr, sel, dat_w,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter_rr_watchdog.sv
// Bus watchdog: counts consecutive strobe cycles without an ack and flags
// an abort on the TIMEOUT-th one so a hung peripheral cannot lock the bus.
module wb_watchdog #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic abort
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // An ack in the would-be abort cycle wins: abort requires ~ack.
  assign abort = stb & ~ack & (r_cnt == LP_LAST);

  // Stall counter: cleared by idle, ack or abort; otherwise saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (!stb || ack || abort)  r_cnt <= '0;
    else if (r_cnt != LP_SAT)       r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Two-master round-robin Wishbone classic arbiter with bus watchdog.
// A grant is held for the whole cycle (cyc high) so multi-beat and RMW
// cycles are never split; the watchdog forces the bus back to IDLE.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  wb_arbiter_rr_if.slave    m0,
  wb_arbiter_rr_if.slave    m1,
  wb_arbiter_rr_if.master   s,
  output logic [1:0]        gnt
);

  arb_state_t r_state;
  arb_state_t w_next;
  idx_t       r_last;
  logic       w_stb;
  logic       w_abort;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .stb   (w_stb),
    .ack   (s.ack),
    .abort (w_abort)
  );

  // Grant state and last-granted master; last follows every grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0)      r_last <= 1'b0;
      else if (w_next == GNT1) r_last <= 1'b1;
    end
  end

  // Next grant: hold while the owner keeps cyc, hand off directly when it drops.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = arb_pick(m0.cyc, m1.cyc, r_last);
      GNT0: begin
        if (w_abort)      w_next = IDLE;
        else if (!m0.cyc) w_next = arb_pick(m0.cyc, m1.cyc, r_last);
      end
      GNT1: begin
        if (w_abort)      w_next = IDLE;
        else if (!m1.cyc) w_next = arb_pick(m0.cyc, m1.cyc, r_last);
      end
      default: w_next = IDLE;
    endcase
  end

  // Slave-side mux from the granted master; bus driven to zero when idle.
  always_comb begin
    s.cyc   = 1'b0;
    w_stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.sel   = '0;
    s.dat_w = '0;
    case (r_state)
      GNT0: begin
        s.cyc   = m0.cyc;
        w_stb   = m0.stb;
        s.we    = m0.we;
        s.adr   = m0.adr;
        s.sel   = m0.sel;
        s.dat_w = m0.dat_w;
      end
      GNT1: begin
        s.cyc   = m1.cyc;
        w_stb   = m1.stb;
        s.we    = m1.we;
        s.adr   = m1.adr;
        s.sel   = m1.sel;
        s.dat_w = m1.dat_w;
      end
      default: ;
    endcase
  end

  assign s.stb = w_stb;

  // Responses reach only the granted master; read data is broadcast.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = (r_state == GNT0) & s.ack & ~w_abort;
  assign m1.ack   = (r_state == GNT1) & s.ack & ~w_abort;
  assign m0.err   = (r_state == GNT0) & w_abort;
  assign m1.err   = (r_state == GNT1) & w_abort;
  assign gnt      = {r_state == GNT1, r_state == GNT0};

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: reset, single read, tie-break and
// handoff, round-robin contention, watchdog abort, ack-vs-abort race and
// asynchronous reset in mid-transfer.
module tb_wb_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] dat;
  } sb_t;
  sb_t sb_q[$];

  wb_arbiter_rr_if m0_bus ();
  wb_arbiter_rr_if m1_bus ();
  wb_arbiter_rr_if s_bus ();

  wb_arbiter_rr #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_bus),
    .m1  (m1_bus),
    .s   (s_bus),
    .gnt (gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] dat);
    sb_t e;
    e.tag = tag;
    e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.dat);
    end
  endtask

  task automatic m_drv(input int n, input logic cyc, input logic we,
                       input logic [29:0] adr, input logic [31:0] dat);
    if (n == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.sel = cyc ? 4'hF : 4'h0; m0_bus.dat_w = dat;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.sel = cyc ? 4'hF : 4'h0; m1_bus.dat_w = dat;
    end
  endtask

  initial begin
    rst = 1'b0;
    m_drv(0, 1'b0, 1'b0, '0, '0);
    m_drv(1, 1'b0, 1'b0, '0, '0);
    s_bus.ack = 1'b0; s_bus.dat_r = '0; s_bus.err = 1'b0;
    #2 rst = 1'b1;
    tick(); tick();
    look();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_scyc", 32'(s_bus.cyc), 32'd0);
    chk("rst_sstb", 32'(s_bus.stb), 32'd0);
    chk("rst_sadr", 32'(s_bus.adr), 32'd0);
    chk("rst_m0ack", 32'(m0_bus.ack), 32'd0);
    chk("rst_m1err", 32'(m1_bus.err), 32'd0);

    // single m0 read at 0x100, slave acks after two wait states
    tick(); rst = 1'b0; m_drv(0, 1'b1, 1'b0, 30'h100, '0);
    look();
    chk("t1_gnt_lat", 32'(gnt), 32'd0);
    chk("t1_scyc_lat", 32'(s_bus.cyc), 32'd0);
    tick(); look();
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_sadr", 32'(s_bus.adr), 32'h100);
    chk("t1_scyc", 32'(s_bus.cyc), 32'd1);
    chk("t1_wait1_ack", 32'(m0_bus.ack), 32'd0);
    sb_push("t1_rdata", 32'hCAFE_0100);
    tick(); look();
    chk("t1_wait2_ack", 32'(m0_bus.ack), 32'd0);
    tick(); s_bus.ack = 1'b1; s_bus.dat_r = 32'hCAFE_0100; look();
    chk("t1_ack", 32'(m0_bus.ack), 32'd1);
    chk("t1_m1ack", 32'(m1_bus.ack), 32'd0);
    sb_pop(m0_bus.dat_r);
    tick(); s_bus.ack = 1'b0; m_drv(0, 1'b0, 1'b0, '0, '0); look();
    chk("t1_scyc_drop", 32'(s_bus.cyc), 32'd0);
    chk("t1_gnt_hold", 32'(gnt), 32'd1);
    tick(); look();
    chk("t1_idle", 32'(gnt), 32'd0);

    // fresh reset, both request together: m0 first, then direct handoff
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    m_drv(0, 1'b1, 1'b0, 30'h200, '0);
    m_drv(1, 1'b1, 1'b0, 30'h300, '0);
    look();
    chk("t2_gnt_lat", 32'(gnt), 32'd0);
    tick(); s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_A200; sb_push("t2_m0_rdata", 32'h0000_A200);
    look();
    chk("t2_gnt_m0", 32'(gnt), 32'd1);
    chk("t2_m0ack", 32'(m0_bus.ack), 32'd1);
    chk("t2_m1ack_blocked", 32'(m1_bus.ack), 32'd0);
    sb_pop(m0_bus.dat_r);
    tick(); s_bus.ack = 1'b0; m_drv(0, 1'b0, 1'b0, '0, '0); look();
    chk("t2_scyc_gap", 32'(s_bus.cyc), 32'd0);
    chk("t2_gnt_still_m0", 32'(gnt), 32'd1);
    tick(); look();
    chk("t2_gnt_handoff", 32'(gnt), 32'd2);
    chk("t2_sadr_m1", 32'(s_bus.adr), 32'h300);
    tick(); s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_B300; sb_push("t2_m1_rdata", 32'h0000_B300);
    look();
    chk("t2_m1ack", 32'(m1_bus.ack), 32'd1);
    chk("t2_m0ack", 32'(m0_bus.ack), 32'd0);
    sb_pop(m1_bus.dat_r);
    tick(); s_bus.ack = 1'b0; m_drv(1, 1'b0, 1'b0, '0, '0); look();
    tick(); look();
    chk("t2_idle", 32'(gnt), 32'd0);

    // repeated ties: grants must alternate starting with m0
    for (int r = 0; r < 4; r++) begin
      tick();
      m_drv(0, 1'b1, 1'b0, 30'h10 + 30'(r), '0);
      m_drv(1, 1'b1, 1'b0, 30'h20 + 30'(r), '0);
      look();
      chk($sformatf("t3_idle_%0d", r), 32'(gnt), 32'd0);
      tick();
      s_bus.ack = 1'b1; s_bus.dat_r = 32'hD000_0000 | 32'(r);
      sb_push($sformatf("t3_rdata_%0d", r), 32'hD000_0000 | 32'(r));
      look();
      chk($sformatf("t3_gnt_%0d", r), 32'(gnt), (r % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("t3_m0ack_%0d", r), 32'(m0_bus.ack), (r % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_m1ack_%0d", r), 32'(m1_bus.ack), (r % 2 == 0) ? 32'd0 : 32'd1);
      sb_pop((r % 2 == 0) ? m0_bus.dat_r : m1_bus.dat_r);
      tick();
      s_bus.ack = 1'b0;
      m_drv(0, 1'b0, 1'b0, '0, '0);
      m_drv(1, 1'b0, 1'b0, '0, '0);
      look();
    end

    // m1 stalls: slave never acks, abort on the 8th strobe cycle
    tick(); m_drv(1, 1'b1, 1'b0, 30'h400, '0); look();
    for (int i = 1; i <= 8; i++) begin
      tick(); look();
      if (i == 1) chk("t4_gnt_m1", 32'(gnt), 32'd2);
      chk($sformatf("t4_err_%0d", i), 32'(m1_bus.err), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("t4_ack_supp", 32'(m1_bus.ack), 32'd0);
    chk("t4_m0err", 32'(m0_bus.err), 32'd0);
    m_drv(0, 1'b1, 1'b0, 30'h500, '0);
    tick(); look();
    chk("t4_gnt_idle", 32'(gnt), 32'd0);
    chk("t4_err_clear", 32'(m1_bus.err), 32'd0);
    tick(); look();
    chk("t4_retry_other", 32'(gnt), 32'd1);
    m_drv(1, 1'b0, 1'b0, '0, '0);

    // m0 is on its 1st stall cycle; ack arrives exactly on the 8th
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (i == 8) begin
        s_bus.ack = 1'b1; s_bus.dat_r = 32'hE500_0008;
        sb_push("t5_rdata", 32'hE500_0008);
      end
      look();
      if (i < 8) chk($sformatf("t5_err_%0d", i), 32'(m0_bus.err), 32'd0);
    end
    chk("t5_ack_wins", 32'(m0_bus.ack), 32'd1);
    chk("t5_no_err", 32'(m0_bus.err), 32'd0);
    sb_pop(m0_bus.dat_r);
    // next beat stalls: a full fresh timeout proves the counter cleared
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) s_bus.ack = 1'b0;
      look();
      chk($sformatf("t5_cnt_err_%0d", j), 32'(m0_bus.err), (j == 8) ? 32'd1 : 32'd0);
    end
    m_drv(0, 1'b0, 1'b0, '0, '0);
    tick(); look();
    chk("t5_idle", 32'(gnt), 32'd0);

    // reset lands in the middle of an m0 write
    tick(); m_drv(0, 1'b1, 1'b1, 30'h500, 32'h1234_5678); look();
    tick(); look();
    chk("t6_gnt", 32'(gnt), 32'd1);
    chk("t6_swe", 32'(s_bus.we), 32'd1);
    chk("t6_sdatw", s_bus.dat_w, 32'h1234_5678);
    #1 rst = 1'b1; s_bus.ack = 1'b1;
    #1;
    chk("t6_scyc", 32'(s_bus.cyc), 32'd0);
    chk("t6_gnt_rst", 32'(gnt), 32'd0);
    chk("t6_m0ack", 32'(m0_bus.ack), 32'd0);
    chk("t6_m0err", 32'(m0_bus.err), 32'd0);
    tick(); rst = 1'b0; s_bus.ack = 1'b0; m_drv(0, 1'b0, 1'b0, '0, '0); look();
    chk("t6_post_gnt", 32'(gnt), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
